reg_bank_wr: RTL and testbench
==============================

# reg_bank_wr

Write side of the 4-entry register bank: accepts write requests over a valid/ready handshake and steers each data word into one of four WIDTH-bit registers through a 1-to-4 address decoder. It also performs a sequenced clear of all registers on request. The registers are exposed as one flattened bus, which feeds the bank's 4:1 read-select path.

## Interface
- WIDTH, default 8: bits per register.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- wr_valid  input  1  write request present.
- wr_ready  output  1  block can accept a write this cycle.
- wr_addr  input  2  target register index, 0..3.
- wr_data  input  WIDTH  data to store.
- wr_ack  output  1  one-cycle pulse acknowledging a committed write.
- clr_req  input  1  request to zero all four registers.
- clr_busy  output  1  clear sweep in progress.
- clr_done  output  1  one-cycle pulse when the sweep finishes.
- wr_en  output  4  one-hot write strobe applied in the current cycle (all zero when idle).
- q  output  4*WIDTH  register contents; register i is q[i*WIDTH +: WIDTH].

## Operation
- FSM states: IDLE and CLEAR. 2-bit sweep counter clr_idx.
- IDLE:
  - wr_ready = 1.
  - A write is accepted on any edge where wr_valid && wr_ready. At that edge, reg[wr_addr] <= wr_data.
  - wr_en = decode(wr_addr) while wr_valid is high; otherwise 0.
  - clr_req sampled high: next state is CLEAR and clr_idx <= 0.
- CLEAR:
  - wr_ready = 0 and clr_busy = 1.
  - Each edge: reg[clr_idx] <= 0 and clr_idx increments. wr_en = decode(clr_idx).
  - After clr_idx = 3 is zeroed, next state is IDLE.
- Simultaneous wr_valid and clr_req in IDLE: the write is accepted and committed at that edge, and CLEAR starts on the next cycle. The sweep therefore overwrites it; the written value is visible for one cycle only.
- clr_req while in CLEAR is ignored and does not restart the sweep.
- wr_valid while in CLEAR is not accepted. The requester holds wr_addr and wr_data stable until wr_ready.
- No read-side logic in this block. Registers are never written except by an accepted write or the sweep.

## Timing
- Reset values: every register 0, state IDLE, clr_idx 0, wr_ack 0, clr_done 0, clr_busy 0.
- Outputs while rst_n is low: wr_ready = 1 (IDLE), wr_en follows wr_valid as in IDLE, but reset wins and no write commits.
- Write latency: the value appears on q the cycle after the accepting edge. wr_ack is high for exactly that cycle.
- Back-to-back writes: one per cycle at full throughput. Same-address writes are last-wins, each visible for one cycle.
- Clear sweep: clr_req sampled at edge k; clr_busy is high for cycles k+1..k+4.
  - Register i reads 0 from cycle k+2+i.
  - clr_done pulses in cycle k+5, with wr_ready back to 1 in the same cycle.
  - A total of 4 cycles with ready low.
- Reset mid-sweep: FSM returns to IDLE, all registers are 0, and no clr_done pulse is generated.
- wr_ready and wr_en are combinational from state, clr_idx and the request inputs. q, wr_ack, clr_done and clr_busy are registered.

## Structure
- Package reg_bank_pkg holds:
  - NREG = 4 and ADDR_W = 2.
  - The FSM state encoding, shared with any future bank controller.
- Sub-module demux1to4: a 2-bit select plus an enable in, a 4-bit one-hot out. It is the write-side counterpart of the bank's read mux and drives wr_en.
- The select is a mux of wr_addr and clr_idx by state.
- Storage: four WIDTH-bit registers, each with its own enable.

## Test plan
- Reset: hold rst_n low for 2 cycles with wr_valid=1, addr=2, data=0xAA -> q stays 0, no wr_ack, wr_ready=1 after release.
- Writes: write 0x11, 0x22, 0x33, 0x44 to addresses 0..3 on consecutive cycles -> q=0x44332211 one cycle after the last accept, with four consecutive wr_ack pulses.
- Sweep: pulse clr_req with q=0x44332211 -> clr_busy is high for 4 cycles.
  - q goes 0x44332200, 0x44330000, 0x44000000, 0x00000000 on successive cycles.
  - clr_done pulses once, then wr_ready=1.
- Collision: wr_valid with addr=1, data=0x5A together with clr_req in IDLE -> q[15:8]=0x5A for one cycle, then zeroed by the sweep.
- Blocking: wr_valid held during CLEAR -> no accept and no wr_ack until the first IDLE cycle, then commits once.
- Reset mid-sweep: assert rst_n low on the 2nd CLEAR cycle -> FSM IDLE, q=0, and clr_done is never seen.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared definitions for the 4-entry register bank: sizes and the controller
// state encoding reused by the write side and any future bank controller.
package reg_bank_pkg;

    localparam int NREG   = 4;
    localparam int ADDR_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } bank_state_e;

endpackage

// File: rtl/demux1to4.sv
// 1-to-4 enable decoder; the write-side counterpart of the bank's 4:1 read mux.
module demux1to4
    import reg_bank_pkg::*;
(
    input  logic [ADDR_W-1:0] sel,
    input  logic              en,
    output logic [NREG-1:0]   out
);

    always_comb begin
        out = '0;
        if (en) begin
            out[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_bank_wr.sv
// Write side of the 4-entry register bank: valid/ready writes into four
// registers plus a one-register-per-cycle clear sweep.
module reg_bank_wr
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    output logic                  wr_ack,
    input  logic                  clr_req,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic [NREG-1:0]       wr_en,
    output logic [NREG*WIDTH-1:0] q
);

    bank_state_e       state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic              wr_ack_q, wr_ack_d;
    logic              clr_done_q, clr_done_d;
    logic              clr_busy_q, clr_busy_d;
    logic [WIDTH-1:0]  regs_q [NREG];
    logic [WIDTH-1:0]  regs_d [NREG];
    logic [ADDR_W-1:0] dec_sel;
    logic              dec_en;

    always_comb begin
        state_d    = state_q;
        clr_idx_d  = clr_idx_q;
        wr_ack_d   = 1'b0;
        clr_done_d = 1'b0;
        wr_ready   = 1'b0;
        dec_sel    = wr_addr;
        dec_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wr_ready = 1'b1;
                dec_en   = wr_valid;
                wr_ack_d = wr_valid;
                // A write arriving with clr_req still commits; the sweep follows.
                if (clr_req) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = '0;
                end
            end
            ST_CLEAR: begin
                dec_sel   = clr_idx_q;
                dec_en    = 1'b1;
                clr_idx_d = clr_idx_q + 2'd1;
                if (clr_idx_q == 2'd3) begin
                    state_d    = ST_IDLE;
                    clr_done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        clr_busy_d = (state_d == ST_CLEAR);
    end

    demux1to4 u_demux (
        .sel (dec_sel),
        .en  (dec_en),
        .out (wr_en)
    );

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_en[i]) begin
                regs_d[i] = (state_q == ST_CLEAR) ? '0 : wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            clr_idx_q  <= '0;
            wr_ack_q   <= 1'b0;
            clr_done_q <= 1'b0;
            clr_busy_q <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            wr_ack_q   <= wr_ack_d;
            clr_done_q <= clr_done_d;
            clr_busy_q <= clr_busy_d;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            q[i*WIDTH +: WIDTH] = regs_q[i];
        end
    end

    assign wr_ack   = wr_ack_q;
    assign clr_done = clr_done_q;
    assign clr_busy = clr_busy_q;

endmodule

// File: tb/tb_reg_bank_wr.sv
// Self-checking bench for reg_bank_wr: per-scenario tasks plus a write
// scoreboard that is popped whenever the DUT acknowledges a write.
module tb_reg_bank_wr;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic [1:0]       addr;
        logic [WIDTH-1:0] data;
    } wr_item_t;

    logic               clk;
    logic               rst_n;
    logic               wr_valid;
    logic               wr_ready;
    logic [1:0]         wr_addr;
    logic [WIDTH-1:0]   wr_data;
    logic               wr_ack;
    logic               clr_req;
    logic               clr_busy;
    logic               clr_done;
    logic [3:0]         wr_en;
    logic [4*WIDTH-1:0] q;

    int       n_checks = 0;
    int       n_fail   = 0;
    wr_item_t sb[$];

    reg_bank_wr #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .wr_en    (wr_en),
        .q        (q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every acknowledged write must match the oldest expected write
    initial begin
        wr_item_t e;
        forever begin
            @(posedge clk);
            #1;
            if (wr_ack === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL sb_unexpected_ack: wr_ack=1 at %0t, required no ack", $time);
                end else begin
                    e = sb.pop_front();
                    if (q[e.addr*WIDTH +: WIDTH] !== e.data) begin
                        n_fail++;
                        $display("[TB] FAIL sb_write_data addr %0d: got %h, required %h", e.addr, q[e.addr*WIDTH +: WIDTH], e.data);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst_n    = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 2'd2;
        wr_data  = 8'hAA;
        clr_req  = 1'b0;
        tick();
        tick();
        n_checks++;
        if (q !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_q: got %h, required %h", q, 32'h0);
        end
        n_checks++;
        if (wr_ack !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_ack: got %b, required 0", wr_ack);
        end
        n_checks++;
        if (wr_en !== 4'b0100) begin
            n_fail++;
            $display("[TB] FAIL reset_wr_en: got %b, required 0100", wr_en);
        end
        rst_n    = 1'b1;
        wr_valid = 1'b0;
        #1;
        n_checks++;
        if ({wr_ready, clr_busy, clr_done} !== 3'b100) begin
            n_fail++;
            $display("[TB] FAIL reset_release_flags: got ready/busy/done=%b, required 100", {wr_ready, clr_busy, clr_done});
        end
        tick();
        n_checks++;
        if (q !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_no_commit: got %h, required %h", q, 32'h0);
        end
    endtask

    task automatic test_writes();
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 2'(i);
            wr_data  = 8'((i + 1) * 8'h11);
            #1;
            n_checks++;
            if (wr_ready !== 1'b1 || wr_en !== 4'(1 << i)) begin
                n_fail++;
                $display("[TB] FAIL write_ready_en %0d: got ready=%b en=%b, required 1 and %b", i, wr_ready, wr_en, 4'(1 << i));
            end
            sb.push_back('{addr: 2'(i), data: 8'((i + 1) * 8'h11)});
            tick();
            n_checks++;
            if (wr_ack !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL write_ack %0d: got %b, required 1", i, wr_ack);
            end
        end
        wr_valid = 1'b0;
        n_checks++;
        if (q !== 32'h44332211) begin
            n_fail++;
            $display("[TB] FAIL write_all_q: got %h, required %h", q, 32'h44332211);
        end
        tick();
        n_checks++;
        if (wr_ack !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL write_ack_end: got %b, required 0", wr_ack);
        end
    endtask

    task automatic test_sweep();
        logic [31:0] exp_q [4];
        exp_q[0] = 32'h44332200;
        exp_q[1] = 32'h44330000;
        exp_q[2] = 32'h44000000;
        exp_q[3] = 32'h00000000;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int j = 0; j < 4; j++) begin
            #1;
            n_checks++;
            if ({clr_busy, wr_ready, clr_done} !== 3'b100 || wr_en !== 4'(1 << j)) begin
                n_fail++;
                $display("[TB] FAIL sweep_flags %0d: got busy/ready/done=%b en=%b, required 100 and %b", j, {clr_busy, wr_ready, clr_done}, wr_en, 4'(1 << j));
            end
            tick();
            n_checks++;
            if (q !== exp_q[j]) begin
                n_fail++;
                $display("[TB] FAIL sweep_q %0d: got %h, required %h", j, q, exp_q[j]);
            end
        end
        n_checks++;
        if ({clr_done, clr_busy, wr_ready} !== 3'b101) begin
            n_fail++;
            $display("[TB] FAIL sweep_done: got done/busy/ready=%b, required 101", {clr_done, clr_busy, wr_ready});
        end
        tick();
        n_checks++;
        if (clr_done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL sweep_done_pulse: got %b, required 0", clr_done);
        end
    endtask

    task automatic test_collision();
        wr_valid = 1'b1;
        wr_addr  = 2'd1;
        wr_data  = 8'h5A;
        clr_req  = 1'b1;
        sb.push_back('{addr: 2'd1, data: 8'h5A});
        tick();
        wr_valid = 1'b0;
        clr_req  = 1'b0;
        n_checks++;
        if (q[15:8] !== 8'h5A || clr_busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL collision_visible: got q1=%h busy=%b, required 5a and 1", q[15:8], clr_busy);
        end
        tick();
        tick();
        n_checks++;
        if (q[15:8] !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL collision_cleared: got %h, required 00", q[15:8]);
        end
        tick();
        tick();
        n_checks++;
        if (clr_done !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL collision_done: got %b, required 1", clr_done);
        end
        tick();
    endtask

    task automatic test_blocking();
        int n_low;
        clr_req = 1'b1;
        tick();
        clr_req  = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 2'd3;
        wr_data  = 8'hC3;
        n_low    = 0;
        #1;
        while (wr_ready !== 1'b1 && n_low < 10) begin
            n_checks++;
            if (wr_ack !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL block_ack_during_clear: got %b, required 0", wr_ack);
            end
            tick();
            n_low++;
        end
        n_checks++;
        if (n_low != 4) begin
            n_fail++;
            $display("[TB] FAIL block_ready_low_cycles: got %0d, required 4", n_low);
        end
        sb.push_back('{addr: 2'd3, data: 8'hC3});
        tick();
        wr_valid = 1'b0;
        n_checks++;
        if (wr_ack !== 1'b1 || q[31:24] !== 8'hC3) begin
            n_fail++;
            $display("[TB] FAIL block_commit: got ack=%b q3=%h, required 1 and c3", wr_ack, q[31:24]);
        end
        tick();
        n_checks++;
        if (wr_ack !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL block_single_commit: got %b, required 0", wr_ack);
        end
    endtask

    task automatic test_back_to_back();
        wr_valid = 1'b1;
        wr_addr  = 2'd2;
        wr_data  = 8'hA1;
        sb.push_back('{addr: 2'd2, data: 8'hA1});
        tick();
        wr_data = 8'hB2;
        sb.push_back('{addr: 2'd2, data: 8'hB2});
        tick();
        wr_addr = 2'd0;
        wr_data = 8'h99;
        sb.push_back('{addr: 2'd0, data: 8'h99});
        tick();
        wr_valid = 1'b0;
        n_checks++;
        if (q !== 32'hC3B20099) begin
            n_fail++;
            $display("[TB] FAIL b2b_last_wins: got %h, required %h", q, 32'hC3B20099);
        end
        tick();
    endtask

    task automatic test_reset_mid_sweep();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if (q !== 32'h0 || clr_busy !== 1'b0 || wr_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midsweep_reset: got q=%h busy=%b ready=%b, required 0, 0, 1", q, clr_busy, wr_ready);
        end
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (clr_done !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL midsweep_no_done %0d: got %b, required 0", k, clr_done);
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_writes();
        test_sweep();
        test_collision();
        test_blocking();
        test_back_to_back();
        test_reset_mid_sweep();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL sb_missing_acks: got %0d pending, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
